hazard_controller: RTL and testbench

//  Pipeline sequencer between the ID-stage decoder and the EX/MEM/WB stages. Its duties:
//  - track in-flight destination registers in a 3-entry scoreboard (EX, MEM, WB)
//  - select operand forwarding
//  - insert load-use bubbles
//  - serialise CSR ops (drain before issue, block younger ops until the CSR retires)
//  - squash IF/ID on EX redirects

---
 rtl/riscv_pipe_pkg.sv | 20 ++
 rtl/hazard_scoreboard.sv | 36 +++
 rtl/hazard_controller.sv | 101 ++++++++++
 tb/tb_hazard_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types and helpers for the pipeline hazard controller
package riscv_pipe_pkg;
  localparam int SB_AW = 5;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_e;
  typedef enum logic [1:0] {RUN, DRAIN, CSR_BUSY, FLUSH} hzd_state_e;
  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             wen;
    logic             is_load;
    logic             is_csr;
  } sb_entry_t;
  function automatic logic sb_hit(input sb_entry_t e, input logic [SB_AW-1:0] src);
    return e.valid & e.wen & (e.rd == src) & (src != '0);
  endfunction
  // match bit 0 is EX (youngest), bit 2 is WB (oldest)
  function automatic fwd_sel_e fwd_pick(input logic [2:0] m);
    return m[0] ? FWD_EX : m[1] ? FWD_MEM : m[2] ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB shift of in-flight destinations with per-stage source matches
module hazard_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze_i,
  input  logic             push_i,
  input  sb_entry_t        id_i,
  input  logic [SB_AW-1:0] rs1_i,
  input  logic [SB_AW-1:0] rs2_i,
  input  logic [1:0]       use_i,
  output logic             empty_o,
  output logic             ex_load_o,
  output logic             wb_csr_o,
  output logic [2:0]       m1_o,
  output logic [2:0]       m2_o
);
  sb_entry_t ex_q, mem_q, wb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze_i) begin
      ex_q  <= push_i ? id_i : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end
  assign empty_o   = ~(ex_q.valid | mem_q.valid | wb_q.valid);
  assign ex_load_o = ex_q.valid & ex_q.is_load;
  assign wb_csr_o  = wb_q.valid & wb_q.is_csr;
  assign m1_o = {3{use_i[1]}} & {sb_hit(wb_q, rs1_i), sb_hit(mem_q, rs1_i), sb_hit(ex_q, rs1_i)};
  assign m2_o = {3{use_i[0]}} & {sb_hit(wb_q, rs2_i), sb_hit(mem_q, rs2_i), sb_hit(ex_q, rs2_i)};
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and forwarding source for the ID stage
module hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW       = SB_AW,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [1:0]        id_dep_check,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wb_wen,
  input  logic              id_is_load,
  input  logic              id_is_csr_op,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2,
  output logic              csr_busy
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  hzd_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, live_q;
  logic sb_empty, ex_load, wb_csr, issue;
  logic [2:0] m1, m2;
  logic redir, flush_any, csr_req, csr_hold, load_use;
  sb_entry_t id_e;
  assign id_e = '{valid: 1'b1, rd: id_rd, wen: id_wb_wen, is_load: id_is_load, is_csr: id_is_csr_op};
  assign issue = id_valid & ~stall_id & ~flush_id & ~bubble_ex;
  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .freeze_i (mem_busy),
    .push_i   (issue),
    .id_i     (id_e),
    .rs1_i    (id_rs1),
    .rs2_i    (id_rs2),
    .use_i    (id_dep_check),
    .empty_o  (sb_empty),
    .ex_load_o(ex_load),
    .wb_csr_o (wb_csr),
    .m1_o     (m1),
    .m2_o     (m2)
  );
  // live_q keeps every output low on the first cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      live_q  <= 1'b1;
    end
  end
  assign redir     = live_q & ~mem_busy & (ex_redirect | pend_q) & (state_q != CSR_BUSY);
  assign flush_any = redir | (state_q == FLUSH);
  assign csr_req   = id_valid & id_is_csr_op;
  assign csr_hold  = (state_q == CSR_BUSY) | ((state_q == DRAIN) | (state_q == RUN) & csr_req) & ~sb_empty;
  assign load_use  = id_valid & ex_load & (m1[0] | m2[0]);
  assign pend_d    = mem_busy & (pend_q | ex_redirect);
  // the redirect cycle is the first of FLUSH_CYCLES squash cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (live_q && !mem_busy) begin
      case (state_q)
        RUN:      state_d = csr_req ? (sb_empty ? CSR_BUSY : DRAIN) : RUN;
        DRAIN:    state_d = sb_empty ? CSR_BUSY : DRAIN;
        CSR_BUSY: state_d = wb_csr ? RUN : CSR_BUSY;
        default:  state_d = (cnt_q <= CW'(1)) ? RUN : FLUSH;
      endcase
      cnt_d = (state_q == FLUSH && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      if (redir) begin
        state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end
    end
  end
  always_comb begin
    stall_if  = live_q & (mem_busy | ~flush_any & (csr_hold | load_use));
    stall_id  = stall_if;
    flush_id  = live_q & ~mem_busy & flush_any;
    bubble_ex = live_q & ~mem_busy & (flush_any | csr_hold | load_use);
    fwd_rs1   = live_q ? fwd_pick(m1) : FWD_RF;
    fwd_rs2   = live_q ? fwd_pick(m2) : FWD_RF;
    csr_busy  = live_q & ((state_q == DRAIN) | (state_q == CSR_BUSY));
  end
  a_no_redir_in_csr: assert property (@(posedge clk) disable iff (rst) !(ex_redirect && state_q == CSR_BUSY));
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors into an expectation queue, checked by a negedge monitor
module tb_hazard_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_wb_wen = 1'b0, id_is_load = 1'b0, id_is_csr_op = 1'b0;
  logic ex_redirect = 1'b0, mem_busy = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0] id_dep_check = '0;
  logic stall_if, stall_id, bubble_ex, flush_id, csr_busy;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [8:0] act;
  logic [8:0] exp_q[$];
  string nm_q[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  hazard_controller dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_dep_check(id_dep_check), .id_rd(id_rd), .id_wb_wen(id_wb_wen), .id_is_load(id_is_load),
    .id_is_csr_op(id_is_csr_op), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .csr_busy(csr_busy)
  );
  assign act = {stall_if, stall_id, bubble_ex, flush_id, fwd_rs1, fwd_rs2, csr_busy};
  // order: {stall_if, stall_id, bubble_ex, flush_id, fwd_rs1, fwd_rs2, csr_busy}
  function automatic logic [8:0] x(input int st, bx, fl, f1, f2, cb);
    return {st[0], st[0], bx[0], fl[0], f1[1:0], f2[1:0], cb[0]};
  endfunction
  always @(negedge clk) begin
    logic [8:0] e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b (si,sd,bx,fl,f1,f2,cb)", n, act, e);
      end
    end
  end
  task automatic step(input int r, v, s1, s2, dep, rd, wen, ld, csr, rdr, busy,
                      input logic [8:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r[0];
    id_valid = v[0];
    id_rs1 = 5'(s1);
    id_rs2 = 5'(s2);
    id_dep_check = 2'(dep);
    id_rd = 5'(rd);
    id_wb_wen = wen[0];
    id_is_load = ld[0];
    id_is_csr_op = csr[0];
    ex_redirect = rdr[0];
    mem_busy = busy[0];
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "drain");
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "post_rst");
    idle(1);
    step(0, 1, 1, 2, 3, 5, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x5");
    step(0, 1, 5, 1, 3, 6, 1, 0, 0, 0, 0, x(0, 0, 0, 1, 0, 0), "fwd_ex");
    idle(3);
    step(0, 1, 1, 2, 3, 5, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x5");
    idle(1);
    step(0, 1, 5, 1, 3, 6, 1, 0, 0, 0, 0, x(0, 0, 0, 2, 0, 0), "fwd_mem");
    idle(3);
    step(0, 1, 1, 2, 3, 5, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x5");
    idle(2);
    step(0, 1, 5, 1, 3, 6, 1, 0, 0, 0, 0, x(0, 0, 0, 3, 0, 0), "fwd_wb");
    idle(3);
    step(0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x5_a");
    step(0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x5_b");
    step(0, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 1, 0), "dep_gate_rs1");
    step(0, 1, 5, 5, 2, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 2, 0, 0), "youngest_mem");
    idle(3);
    step(0, 1, 1, 0, 2, 7, 1, 1, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "lw_x7");
    step(0, 1, 7, 7, 3, 8, 1, 0, 0, 0, 0, x(1, 1, 0, 1, 1, 0), "lu_stall");
    step(0, 1, 7, 7, 3, 8, 1, 0, 0, 0, 0, x(0, 0, 0, 2, 2, 0), "lu_after");
    idle(3);
    step(0, 1, 1, 0, 2, 0, 1, 1, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "lw_x0");
    step(0, 1, 0, 0, 3, 9, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "x0_use");
    idle(3);
    step(0, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x10");
    step(0, 1, 0, 0, 0, 11, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x11");
    step(0, 1, 0, 0, 0, 12, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x12");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(1, 1, 0, 0, 0, 0), "csr_t0");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(1, 1, 0, 0, 0, 1), "drain1");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(1, 1, 0, 0, 0, 1), "drain2");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(0, 0, 0, 0, 0, 1), "csr_issue");
    step(0, 1, 13, 0, 2, 14, 1, 0, 0, 0, 0, x(1, 1, 0, 1, 0, 1), "csr_busy1");
    step(0, 1, 13, 0, 2, 14, 1, 0, 0, 0, 0, x(1, 1, 0, 2, 0, 1), "csr_busy2");
    step(0, 1, 13, 0, 2, 14, 1, 0, 0, 0, 0, x(1, 1, 0, 3, 0, 1), "csr_busy3");
    step(0, 1, 13, 0, 2, 14, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "csr_done");
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, x(0, 1, 1, 0, 0, 0), "redir");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 1, 1, 0, 0, 0), "flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "flush_end");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, x(0, 1, 1, 0, 0, 0), "redir_a");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, x(0, 1, 1, 0, 0, 0), "redir_reload");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 1, 1, 0, 0, 0), "reload_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "reload_end");
    step(0, 1, 1, 0, 2, 7, 1, 1, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "lw_x7_r");
    step(0, 1, 7, 7, 3, 8, 1, 0, 0, 1, 0, x(0, 1, 1, 1, 1, 0), "redir_lu");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 1, 1, 0, 0, 0), "redir_lu_flush");
    idle(3);
    step(0, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x10_r");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 1, 0, x(0, 1, 1, 0, 0, 0), "redir_csr");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 1, 1, 0, 0, 0), "redir_csr_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "csr_dropped");
    idle(3);
    step(0, 1, 0, 0, 0, 20, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x20");
    step(0, 1, 20, 0, 2, 21, 1, 0, 0, 0, 0, x(0, 0, 0, 1, 0, 0), "busy_setup");
    step(0, 1, 20, 21, 3, 22, 1, 0, 0, 0, 1, x(1, 0, 0, 2, 1, 0), "busy1");
    step(0, 1, 20, 21, 3, 22, 1, 0, 0, 1, 1, x(1, 0, 0, 2, 1, 0), "busy2_redir");
    step(0, 1, 20, 21, 3, 22, 1, 0, 0, 0, 1, x(1, 0, 0, 2, 1, 0), "busy3");
    step(0, 1, 20, 21, 3, 22, 1, 0, 0, 0, 1, x(1, 0, 0, 2, 1, 0), "busy4");
    step(0, 1, 20, 21, 3, 22, 1, 0, 0, 0, 0, x(0, 1, 1, 2, 1, 0), "busy_pend_redir");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 1, 1, 0, 0, 0), "busy_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "busy_flush_end");
    idle(3);
    step(0, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "add_x10_d");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(1, 1, 0, 0, 0, 0), "rd_t0");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(1, 1, 0, 0, 0, 1), "rd_drain");
    step(1, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(0, 0, 0, 0, 0, 0), "rst_mid_drain");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "rst_release");
    step(0, 1, 0, 0, 0, 13, 1, 0, 1, 0, 0, x(0, 0, 0, 0, 0, 0), "csr_after_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(1, 1, 0, 0, 0, 1), "csr_b1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(1, 1, 0, 0, 0, 1), "csr_b2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(1, 1, 0, 0, 0, 1), "csr_b3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, x(0, 0, 0, 0, 0, 0), "csr_b_end");
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: %0d vectors unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
